dram_arbiter: RTL

- Shares the single SDRAM controller port between two requesters.
  - CPU side (mem_map): single-word read/write.
  - VGA line fetch: 32-word burst read.
- Sequences each access: issue, wait for `dram_data_ready`, ack.
- VGA has fixed priority, with a starvation guard for the CPU and a watchdog timeout on the controller handshake.
- Sits between mem_map/vga_fetch and the DRAM controller.

---
 rtl/dram_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Arbitrates the single SDRAM controller port between CPU single-word accesses
// and VGA 32-word burst reads. Fixed VGA priority with a CPU starvation guard and a handshake watchdog.
module dram_arbiter #(
  parameter int unsigned MAX_VGA_STREAK = 4,
  parameter int unsigned TIMEOUT        = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        vga_req,
  input  logic [24:0] vga_addr,
  output logic        vga_ack,
  output logic [24:0] dram_addr,
  output logic        dram_write_en,
  output logic        dram_burst_en,
  output logic [15:0] dram_data_in,
  output logic        dram_start,
  input  logic [15:0] dram_read_data,
  input  logic        dram_data_ready,
  output logic        timeout_err
);

  localparam int unsigned WAIT_W   = 6;
  localparam int unsigned STREAK_W = $clog2(MAX_VGA_STREAK + 1);
  localparam int unsigned ADDR_W   = 25;
  localparam int unsigned DATA_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic                grant_vga_q, grant_vga_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [STREAK_W-1:0] vga_streak_q, vga_streak_d;

  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                vga_ack_q, vga_ack_d;
  logic [ADDR_W-1:0]   dram_addr_q, dram_addr_d;
  logic                dram_write_en_q, dram_write_en_d;
  logic                dram_burst_en_q, dram_burst_en_d;
  logic [DATA_W-1:0]   dram_data_in_q, dram_data_in_d;
  logic                dram_start_q, dram_start_d;
  logic                timeout_err_q, timeout_err_d;

  logic any_req_c;
  logic streak_full_c;
  logic pick_vga_c;
  logic timeout_hit_c;

  assign any_req_c     = cpu_req | vga_req;
  assign streak_full_c = (vga_streak_q == STREAK_W'(MAX_VGA_STREAK));
  // VGA wins unless the CPU has been waiting through a full streak of bursts
  assign pick_vga_c    = vga_req & ~(cpu_req & streak_full_c);
  assign timeout_hit_c = (wait_cnt_q == WAIT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req_c) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (dram_data_ready || timeout_hit_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; registers are loaded on entry so each state sees its outputs
  always_comb begin
    grant_vga_d     = grant_vga_q;
    wait_cnt_d      = wait_cnt_q;
    vga_streak_d    = vga_streak_q;
    cpu_ack_d       = 1'b0;
    cpu_rdata_d     = cpu_rdata_q;
    vga_ack_d       = 1'b0;
    dram_addr_d     = dram_addr_q;
    dram_write_en_d = dram_write_en_q;
    dram_burst_en_d = dram_burst_en_q;
    dram_data_in_d  = dram_data_in_q;
    dram_start_d    = 1'b0;
    timeout_err_d   = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          grant_vga_d  = pick_vga_c;
          dram_start_d = 1'b1;
          if (pick_vga_c) begin
            dram_addr_d     = vga_addr;
            dram_write_en_d = 1'b0;
            dram_burst_en_d = 1'b1;
            dram_data_in_d  = '0;
          end else begin
            dram_addr_d     = ADDR_W'(cpu_addr);
            dram_write_en_d = cpu_we;
            dram_burst_en_d = 1'b0;
            dram_data_in_d  = cpu_wdata;
          end
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (dram_data_ready || timeout_hit_c) begin
          cpu_ack_d       = ~grant_vga_q;
          vga_ack_d       = grant_vga_q;
          dram_write_en_d = 1'b0;
          dram_burst_en_d = 1'b0;
          // Ready beats a coincident timeout
          if (dram_data_ready) begin
            if (!grant_vga_q && !dram_write_en_q) cpu_rdata_d = dram_read_data;
          end else begin
            timeout_err_d = 1'b1;
            if (!grant_vga_q && !dram_write_en_q) cpu_rdata_d = '0;
          end
        end
      end
      S_DONE: begin
        if (grant_vga_q && cpu_req) begin
          if (!streak_full_c) vga_streak_d = vga_streak_q + STREAK_W'(1);
        end else begin
          vga_streak_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_vga_q     <= 1'b0;
      wait_cnt_q      <= '0;
      vga_streak_q    <= '0;
      cpu_ack_q       <= 1'b0;
      cpu_rdata_q     <= '0;
      vga_ack_q       <= 1'b0;
      dram_addr_q     <= '0;
      dram_write_en_q <= 1'b0;
      dram_burst_en_q <= 1'b0;
      dram_data_in_q  <= '0;
      dram_start_q    <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      grant_vga_q     <= grant_vga_d;
      wait_cnt_q      <= wait_cnt_d;
      vga_streak_q    <= vga_streak_d;
      cpu_ack_q       <= cpu_ack_d;
      cpu_rdata_q     <= cpu_rdata_d;
      vga_ack_q       <= vga_ack_d;
      dram_addr_q     <= dram_addr_d;
      dram_write_en_q <= dram_write_en_d;
      dram_burst_en_q <= dram_burst_en_d;
      dram_data_in_q  <= dram_data_in_d;
      dram_start_q    <= dram_start_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign cpu_ack       = cpu_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign vga_ack       = vga_ack_q;
  assign dram_addr     = dram_addr_q;
  assign dram_write_en = dram_write_en_q;
  assign dram_burst_en = dram_burst_en_q;
  assign dram_data_in  = dram_data_in_q;
  assign dram_start    = dram_start_q;
  assign timeout_err   = timeout_err_q;

endmodule
